uart_rx: RTL
============

# uart_rx

Serial receiver that sits directly downstream of the UART transmitter on the line and feeds the RX FIFO. It synchronizes the asynchronous `rx` pin, detects start bits with oversampling, and recovers data, optional parity and stop bits using the same frame format parameters as the transmitter. It presents each received word on a valid/ready handshake with per-word error flags.

## Interface
One clock (`clk`). Reset is asynchronous and active-low (`reset_n`).

**Parameters**
- `DATA_BITS`, default 8: data bits per frame, LSB first.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `SYS_CLK`, default 100_000_000: `clk` frequency in Hz.
- `STOP_BITS`, default 1: number of stop bits checked (1 or 2).
- `HAS_PARITY`, default 0: 1 means a parity bit follows the data.
- `PARITY_EVEN`, default 0: 1 selects even parity, 0 selects odd.
- `OVERSAMPLE`, default 16: sample ticks per bit. Must be even and ≥4.

**Ports**
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `rx` in 1: serial line, idle high, asynchronous to `clk`.
- `data` out `DATA_BITS`: received word.
- `valid` out 1: `data` and error flags are valid.
- `ready` in 1: downstream accepts the word.
- `parity_err` out 1: parity mismatch. Valid with `valid`; always 0 when `HAS_PARITY=0`.
- `frame_err` out 1: at least one stop bit sampled as 0. Valid with `valid`.
- `overrun` out 1: one-cycle pulse when a completed frame is dropped.

## Operation
- **Synchronizer:** two-flop synchronizer on `rx`. Both stages and the edge-detect flop reset to 0. A start edge is a synchronized 1→0 transition, so a line held low through reset is never taken as a start bit.
- **Tick generator:** free-running counter, `N = SYS_CLK/(BAUD_RATE*OVERSAMPLE)` (integer divide, N ≥ 2). It emits a one-cycle `tick` every N clocks.
- **Counters:** `samp_cnt` counts 0..OVERSAMPLE-1 and `bit_cnt` counts 0..max(DATA_BITS, STOP_BITS)-1. Both clear on every state entry.
- **FSM states:**
  - IDLE: on a start edge, go to START.
  - START: after OVERSAMPLE/2 ticks (mid start bit), sample the line. If 0, go to DATA. If 1, this is a glitch; go to IDLE with no output.
  - DATA: every OVERSAMPLE ticks, shift the sample into the MSB of the shift register (so LSB first arrives at bit 0). After DATA_BITS samples, go to PARITY if `HAS_PARITY`, else to STOP.
  - PARITY: after OVERSAMPLE ticks, sample the parity bit. `parity_err_next = sample ^ (^shift) ^ ~PARITY_EVEN`, i.e. even parity means the XOR of data and parity bit is 0. Go to STOP.
  - STOP: every OVERSAMPLE ticks, sample one stop bit; any 0 sets `frame_err_next`. After STOP_BITS samples, deliver the word and go to IDLE. The FSM does not wait for the end of the stop bit.
- **Delivery:**
  - If `valid=0` or `ready=1` that cycle, load `data`, `parity_err` and `frame_err`, and set `valid=1`. Simultaneous consume and deliver is legal: the new word replaces the old and `valid` stays 1.
  - Otherwise (`valid=1`, `ready=0`), the new word is discarded. The held word and flags are unchanged, and `overrun` pulses 1 for one cycle.
- **Break:** an all-zero line produces one word, `data=0` with `frame_err=1`. A new start requires the line to return high first.

## Timing
- **Reset values:** `data=0`, `valid=0`, `parity_err=0`, `frame_err=0`, `overrun=0`, FSM in IDLE, all counters 0. Reset mid-frame abandons the frame; no word is delivered.
- **Input latency:** 2 cycles through the synchronizer, plus up to N cycles of tick phase misalignment.
- **Sample points:** bit k (start = 0) is sampled at `OVERSAMPLE/2 + k*OVERSAMPLE` ticks after start detection.
- **Output latency:** `valid` rises one clock after the tick that samples the last stop bit.
- **Handshake:**
  - Transfer occurs on a clock edge with `valid && ready`.
  - `valid` falls the next cycle unless a new word is delivered in the same cycle.
  - `data` and flags are stable while `valid=1 && ready=0`.
  - `ready` has no effect while `valid=0`.

## Test plan
- **Idle after reset:** assert `reset_n=0`, then release with `rx=1` and wait 2000 cycles. All outputs stay at reset values; `valid` never rises.
- **8N1 0xA5 at defaults (N=54):** send one frame with `ready=0`. Required: `valid=1`, `data=8'hA5`, `parity_err=0`, `frame_err=0`, held for 100 cycles. Raise `ready` for one cycle; `valid=0` on the next cycle.
- **Glitch rejection:** drive `rx` low for 5 ticks (270 cycles), then high. No word is delivered, and the FSM returns to IDLE. A subsequent valid frame of 0x3C is received correctly.
- **Framing error:** send 0x55 with the stop bit driven 0, followed by line high. Required: `data=8'h55`, `frame_err=1`.
- **Parity (`HAS_PARITY=1`, `PARITY_EVEN=0`):**
  - 0x0F with parity bit 1 gives `parity_err=0`.
  - 0x0F with parity bit 0 gives `parity_err=1`.
  - Repeat with `PARITY_EVEN=1`: a parity bit of 0 passes.
- **Overrun and reset mid-frame:**
  - Send 0x11 then 0x22 back-to-back with `ready=0`. `overrun` pulses high for exactly 1 cycle and `data` remains 8'h11.
  - Pulse `reset_n` low during the DATA state of a further frame. No word is delivered and all outputs return to reset values.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: two-flop input synchronizer, oversampled start detection, data/parity/stop
// recovery, and a single-entry valid/ready output register with per-word error flags.
module uart_rx #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned SYS_CLK     = 100_000_000,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned HAS_PARITY  = 0,
    parameter int unsigned PARITY_EVEN = 0,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned Div    = SYS_CLK / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned SampW  = $clog2(OVERSAMPLE);
    localparam int unsigned BitMax = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int unsigned BitW   = (BitMax > 1) ? $clog2(BitMax) : 1;
    localparam logic        ParEn  = (HAS_PARITY != 0);
    localparam logic        ParEvn = (PARITY_EVEN != 0);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic                 start_edge;
    logic [DivW-1:0]      div_q;
    logic                 tick;
    state_e               state_q, state_d;
    logic [SampW-1:0]     samp_cnt_q, samp_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS:0]   shift_ext;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 samp_half, samp_last;
    logic                 deliver;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    // Synchronizer and edge-detect history; all reset low so a line held low
    // through reset never produces a 1->0 edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q   <= 1'b0;
            rx_s2_q   <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign start_edge = rx_prev_q & ~rx_s2_q;

    // Free-running oversample tick divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick      = (div_q == DivW'(Div - 1));
    assign samp_half = tick && (samp_cnt_q == SampW'(OVERSAMPLE / 2 - 1));
    assign samp_last = tick && (samp_cnt_q == SampW'(OVERSAMPLE - 1));
    assign shift_ext = {rx_s2_q, shift_q};

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
        end
    end

    // Next-state logic: sampling decisions on tick boundaries, counters cleared on state entry.
    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        deliver    = 1'b0;

        if (tick) begin
            samp_cnt_d = samp_last ? '0 : samp_cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d    = StStart;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                end
            end
            StStart: begin
                if (samp_half) begin
                    // A line back high at mid start bit is a glitch, not a frame.
                    state_d = rx_s2_q ? StIdle : StData;
                end
            end
            StData: begin
                if (samp_last) begin
                    shift_d   = shift_ext[DATA_BITS:1];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
                        state_d = ParEn ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (samp_last) begin
                    perr_acc_d = rx_s2_q ^ (^shift_q) ^ ~ParEvn;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (samp_last) begin
                    if (!rx_s2_q) begin
                        ferr_acc_d = 1'b1;
                    end
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BitW'(STOP_BITS - 1)) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
        end
    end

    // Output register next-state: accept a new word when empty or being drained, else flag overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                perr_d  = perr_acc_q;
                ferr_d  = ferr_acc_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule
